// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: one op in flight, single-beat bus, lane steering and load extension.
// Define MISALIGN_TRAP_EN to trap misaligned accesses; otherwise offending low address bits are dropped.
module mem_stage_lsu #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int REGADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_mem_op,
    input  logic [1:0]            in_size,
    input  logic                  in_signed,
    input  logic [REGADDR_W-1:0]  in_rd_addr,
    input  logic [DATA_W-1:0]     in_rd_data,
    input  logic [DATA_W-1:0]     in_mem_data,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W-1:0]     bus_wdata,
    output logic [DATA_W/8-1:0]   bus_wstb,
    input  logic                  bus_ack,
    input  logic [DATA_W-1:0]     bus_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [REGADDR_W-1:0]  out_rd_addr,
    output logic [DATA_W-1:0]     out_rd_data,
    output logic                  out_we,
    output logic                  out_misalign
);
    localparam int STRB_W = DATA_W / 8;
    localparam int LANE_W = $clog2(STRB_W);

    localparam logic [1:0] OP_LOAD  = 2'd1;
    localparam logic [1:0] OP_STORE = 2'd2;

    typedef enum logic [1:0] { IDLE, BUS, DONE } state_t;

    state_t                 state_q, state_d;
    logic                   bus_req_q, bus_req_d;
    logic                   bus_we_q, bus_we_d;
    logic [ADDR_W-1:0]      bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]      bus_wdata_q, bus_wdata_d;
    logic [STRB_W-1:0]      bus_wstb_q, bus_wstb_d;
    logic                   out_valid_q, out_valid_d;
    logic [REGADDR_W-1:0]   out_rd_addr_q, out_rd_addr_d;
    logic [DATA_W-1:0]      out_rd_data_q, out_rd_data_d;
    logic                   out_we_q, out_we_d;
    logic                   out_misalign_q, out_misalign_d;
    logic [LANE_W-1:0]      lane_q, lane_d;
    logic [1:0]             size_q, size_d;
    logic                   signed_q, signed_d;

    logic [1:0]             op_sz;
    logic [LANE_W-1:0]      op_lane_raw, op_size_lo, op_lane;
    logic [STRB_W-1:0]      op_smask;
    logic [ADDR_W-1:0]      op_addr;
    logic                   is_mem, is_store, trap_hit, accept;

    // Keep the low 2^sz bytes, then fill upward with the sign bit when requested.
    function automatic logic [DATA_W-1:0] load_fmt(input logic [DATA_W-1:0] raw,
                                                   input logic [1:0] sz, input logic sgn);
        logic [DATA_W-1:0] mask, top;
        mask = ~({DATA_W{1'b1}} << (8 << sz));
        top  = raw >> ((8 << sz) - 1);
        return (raw & mask) | ((sgn && top[0]) ? ~mask : '0);
    endfunction

    assign in_ready     = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept       = in_valid && in_ready;
    assign bus_req      = bus_req_q;
    assign bus_we       = bus_we_q;
    assign bus_addr     = bus_addr_q;
    assign bus_wdata    = bus_wdata_q;
    assign bus_wstb     = bus_wstb_q;
    assign out_valid    = out_valid_q;
    assign out_rd_addr  = out_rd_addr_q;
    assign out_rd_data  = out_rd_data_q;
    assign out_we       = out_we_q;
    assign out_misalign = out_misalign_q;

    always_comb begin
        is_mem      = (in_mem_op == OP_LOAD) || (in_mem_op == OP_STORE);
        is_store    = (in_mem_op == OP_STORE);
        op_sz       = (DATA_W == 32 && in_size == 2'd3) ? 2'd2 : in_size;
        op_size_lo  = LANE_W'((1 << op_sz) - 1);
        op_lane_raw = in_rd_data[LANE_W-1:0];
`ifdef MISALIGN_TRAP_EN
        trap_hit    = is_mem && ((op_lane_raw & op_size_lo) != '0);
        op_lane     = op_lane_raw;
`else
        trap_hit    = 1'b0;
        op_lane     = op_lane_raw & ~op_size_lo;
`endif
        op_smask    = ~({STRB_W{1'b1}} << (1 << op_sz));
        op_addr     = ADDR_W'(in_rd_data);
        op_addr[LANE_W-1:0] = '0;
    end

    always_comb begin
        state_d        = state_q;
        bus_req_d      = bus_req_q;
        bus_we_d       = bus_we_q;
        bus_addr_d     = bus_addr_q;
        bus_wdata_d    = bus_wdata_q;
        bus_wstb_d     = bus_wstb_q;
        out_valid_d    = out_valid_q;
        out_rd_addr_d  = out_rd_addr_q;
        out_rd_data_d  = out_rd_data_q;
        out_we_d       = out_we_q;
        out_misalign_d = out_misalign_q;
        lane_d         = lane_q;
        size_d         = size_q;
        signed_d       = signed_q;
        case (state_q)
            IDLE: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d    = 1'b0;
                    out_we_d       = 1'b0;
                    out_misalign_d = 1'b0;
                end
                if (accept) begin
                    out_rd_addr_d = in_rd_addr;
                    if (is_mem && !trap_hit) begin
                        state_d     = BUS;
                        bus_req_d   = 1'b1;
                        bus_we_d    = is_store;
                        bus_addr_d  = op_addr;
                        bus_wdata_d = is_store ? (in_mem_data << {op_lane, 3'b000}) : '0;
                        bus_wstb_d  = is_store ? (op_smask << op_lane) : '0;
                        lane_d      = op_lane;
                        size_d      = op_sz;
                        signed_d    = in_signed;
                    end else begin
                        // NONE/reserved pass straight through; trapped accesses report here too.
                        out_valid_d    = 1'b1;
                        out_misalign_d = trap_hit;
                        out_we_d       = !is_mem && (in_rd_addr != '0);
                        out_rd_data_d  = is_mem ? '0 : in_rd_data;
                    end
                end
            end
            BUS: begin
                if (bus_ack) begin
                    state_d       = DONE;
                    bus_req_d     = 1'b0;
                    bus_we_d      = 1'b0;
                    bus_wstb_d    = '0;
                    out_valid_d   = 1'b1;
                    out_we_d      = !bus_we_q && (out_rd_addr_q != '0);
                    out_rd_data_d = bus_we_q ? '0
                                  : load_fmt(bus_rdata >> {lane_q, 3'b000}, size_q, signed_q);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    out_we_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            bus_req_q      <= 1'b0;
            bus_we_q       <= 1'b0;
            bus_addr_q     <= '0;
            bus_wdata_q    <= '0;
            bus_wstb_q     <= '0;
            out_valid_q    <= 1'b0;
            out_rd_addr_q  <= '0;
            out_rd_data_q  <= '0;
            out_we_q       <= 1'b0;
            out_misalign_q <= 1'b0;
            lane_q         <= '0;
            size_q         <= '0;
            signed_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            bus_req_q      <= bus_req_d;
            bus_we_q       <= bus_we_d;
            bus_addr_q     <= bus_addr_d;
            bus_wdata_q    <= bus_wdata_d;
            bus_wstb_q     <= bus_wstb_d;
            out_valid_q    <= out_valid_d;
            out_rd_addr_q  <= out_rd_addr_d;
            out_rd_data_q  <= out_rd_data_d;
            out_we_q       <= out_we_d;
            out_misalign_q <= out_misalign_d;
            lane_q         <= lane_d;
            size_q         <= size_d;
            signed_q       <= signed_d;
        end
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu (32-bit build): directed table, corner sequences, random ops.
module tb_mem_stage_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [1:0]  in_mem_op, in_size;
    logic        in_signed;
    logic [4:0]  in_rd_addr;
    logic [31:0] in_rd_data, in_mem_data;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstb;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        out_valid, out_ready;
    logic [4:0]  out_rd_addr;
    logic [31:0] out_rd_data;
    logic        out_we, out_misalign;

    int n_cmp = 0;
    int n_bad = 0;

    mem_stage_lsu #(.DATA_W(32), .ADDR_W(32), .REGADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_mem_op(in_mem_op), .in_size(in_size),
        .in_signed(in_signed), .in_rd_addr(in_rd_addr), .in_rd_data(in_rd_data),
        .in_mem_data(in_mem_data),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_wstb(bus_wstb), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd_addr(out_rd_addr),
        .out_rd_data(out_rd_data), .out_we(out_we), .out_misalign(out_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  sz;
        logic        sgn;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] md;
        logic [31:0] rdata;
        int          dly;
        logic        x_req;
        logic [31:0] x_addr;
        logic [3:0]  x_strb;
        logic [31:0] x_wdata;
        logic [31:0] x_data;
        logic        x_we;
        logic        x_mis;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [1:0] sz, input logic sgn,
                                input logic [4:0] rd, input logic [31:0] a, input logic [31:0] md,
                                input logic [31:0] rdata, input int dly, input logic x_req,
                                input logic [31:0] x_addr, input logic [3:0] x_strb,
                                input logic [31:0] x_wdata, input logic [31:0] x_data,
                                input logic x_we, input logic x_mis);
        vec_t v;
        v.op = op; v.sz = sz; v.sgn = sgn; v.rd = rd; v.a = a; v.md = md; v.rdata = rdata;
        v.dly = dly; v.x_req = x_req; v.x_addr = x_addr; v.x_strb = x_strb;
        v.x_wdata = x_wdata; v.x_data = x_data; v.x_we = x_we; v.x_mis = x_mis;
        return v;
    endfunction

    // Reference: byte-level view of lanes, arithmetic sign extension.
    function automatic vec_t model(input vec_t v);
        vec_t   r;
        int     n, l;
        longint val;
        logic [7:0] b;
        r = v;
        r.x_req = 0; r.x_addr = 0; r.x_strb = 0; r.x_wdata = 0; r.x_data = 0; r.x_we = 0; r.x_mis = 0;
        n = 1 << ((v.sz == 2'd3) ? 2 : int'(v.sz));
        l = int'(v.a % 32'd4);
        if (v.op == 2'd1 || v.op == 2'd2) begin
            if (l % n != 0) begin
`ifdef MISALIGN_TRAP_EN
                r.x_mis = 1;
                return r;
`else
                l = l - l % n;
`endif
            end
            r.x_req  = 1;
            r.x_addr = v.a - (v.a % 32'd4);
            if (v.op == 2'd2) begin
                for (int i = 0; i < 4; i++) begin
                    if (i >= l && i < l + n) r.x_strb = r.x_strb | 4'(1 << i);
                    if (i >= l) begin
                        b = 8'(v.md >> (8 * (i - l)));
                        r.x_wdata = r.x_wdata | (32'(b) << (8 * i));
                    end
                end
            end else begin
                val = 0;
                for (int k = 0; k < n; k++) begin
                    b = 8'(v.rdata >> (8 * (l + k)));
                    val = val + (longint'(b) << (8 * k));
                end
                if (v.sgn && val >= (longint'(1) << (8 * n - 1))) val = val - (longint'(1) << (8 * n));
                r.x_data = 32'(val);
                r.x_we   = (v.rd != 0);
            end
        end else begin
            r.x_data = v.a;
            r.x_we   = (v.rd != 0);
        end
        return r;
    endfunction

    task automatic run_op(input vec_t v, input string tag);
        in_valid = 1; in_mem_op = v.op; in_size = v.sz; in_signed = v.sgn;
        in_rd_addr = v.rd; in_rd_data = v.a; in_mem_data = v.md; out_ready = 1;
        chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 0; in_rd_data = $urandom; in_mem_data = $urandom; in_size = 2'($urandom);
        if (v.x_req) begin
            chk({tag, " bus_req"}, 32'(bus_req), 32'd1);
            chk({tag, " bus_addr"}, bus_addr, v.x_addr);
            chk({tag, " bus_we"}, 32'(bus_we), 32'(v.op == 2'd2));
            chk({tag, " busy_out_valid"}, 32'(out_valid), 32'd0);
            if (v.op == 2'd2) begin
                chk({tag, " bus_wstb"}, 32'(bus_wstb), 32'(v.x_strb));
                chk({tag, " bus_wdata"}, bus_wdata, v.x_wdata);
            end
            for (int d = 0; d < v.dly; d++) begin
                @(posedge clk); #1;
                chk({tag, " hold_req"}, 32'(bus_req), 32'd1);
                chk({tag, " hold_addr"}, bus_addr, v.x_addr);
                if (v.op == 2'd2) begin
                    chk({tag, " hold_wstb"}, 32'(bus_wstb), 32'(v.x_strb));
                    chk({tag, " hold_wdata"}, bus_wdata, v.x_wdata);
                end
            end
            bus_ack = 1; bus_rdata = v.rdata;
            @(posedge clk); #1;
            bus_ack = 0; bus_rdata = $urandom;
        end
        chk({tag, " bus_req_off"}, 32'(bus_req), 32'd0);
        chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, " out_rd_addr"}, 32'(out_rd_addr), 32'(v.rd));
        chk({tag, " out_we"}, 32'(out_we), 32'(v.x_we));
        chk({tag, " out_misalign"}, 32'(out_misalign), 32'(v.x_mis));
        if (v.op != 2'd2 && !v.x_mis) chk({tag, " out_rd_data"}, out_rd_data, v.x_data);
        @(posedge clk); #1;
        chk({tag, " out_valid_clr"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[$];
        vec_t v;

        rst = 1; in_valid = 0; in_mem_op = 0; in_size = 0; in_signed = 0; in_rd_addr = 0;
        in_rd_data = 0; in_mem_data = 0; bus_ack = 0; bus_rdata = 0; out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst bus_req", 32'(bus_req), 32'd0);
        chk("rst bus_we", 32'(bus_we), 32'd0);
        chk("rst bus_wstb", 32'(bus_wstb), 32'd0);
        chk("rst bus_addr", bus_addr, 32'd0);
        chk("rst bus_wdata", bus_wdata, 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_we", 32'(out_we), 32'd0);
        chk("rst out_misalign", 32'(out_misalign), 32'd0);
        chk("rst out_rd_data", out_rd_data, 32'd0);
        chk("rst out_rd_addr", 32'(out_rd_addr), 32'd0);
        rst = 0;
        @(posedge clk); #1;
        chk("post_rst in_ready", 32'(in_ready), 32'd1);

        //                 op sz sg rd a            md            rdata        dly req addr         strb  wdata         data          we mis
        tbl.push_back(mk(0, 0, 0, 3, 32'h1234,     32'h0,        32'h0,        0, 0, 32'h0,     4'h0, 32'h0,       32'h1234,     1, 0));
        tbl.push_back(mk(0, 2, 1, 0, 32'hDEAD,     32'h0,        32'h0,        0, 0, 32'h0,     4'h0, 32'h0,       32'hDEAD,     0, 0));
        tbl.push_back(mk(3, 1, 0, 7, 32'h55,       32'h0,        32'h0,        0, 0, 32'h0,     4'h0, 32'h0,       32'h55,       1, 0));
        tbl.push_back(mk(2, 0, 0, 4, 32'h102,      32'hAB,       32'h0,        3, 1, 32'h100,   4'h4, 32'h00AB0000, 32'h0,       0, 0));
        tbl.push_back(mk(1, 1, 0, 5, 32'h2,        32'h0,        32'h80010000, 1, 1, 32'h0,     4'h0, 32'h0,       32'h00008001, 1, 0));
        tbl.push_back(mk(1, 1, 1, 5, 32'h2,        32'h0,        32'h80010000, 0, 1, 32'h0,     4'h0, 32'h0,       32'hFFFF8001, 1, 0));
        tbl.push_back(mk(1, 1, 1, 6, 32'h2,        32'h0,        32'hFFFE0000, 2, 1, 32'h0,     4'h0, 32'h0,       32'hFFFFFFFE, 1, 0));
        tbl.push_back(mk(1, 0, 1, 8, 32'h3,        32'h0,        32'h85123456, 0, 1, 32'h0,     4'h0, 32'h0,       32'hFFFFFF85, 1, 0));
        tbl.push_back(mk(2, 1, 0, 9, 32'h1006,     32'h1234BEEF, 32'h0,        1, 1, 32'h1004,  4'hC, 32'hBEEF0000, 32'h0,       0, 0));
        tbl.push_back(mk(2, 3, 0, 1, 32'h8,        32'h11223344, 32'h0,        0, 1, 32'h8,     4'hF, 32'h11223344, 32'h0,       0, 0));
        tbl.push_back(mk(1, 0, 0, 2, 32'h1,        32'h0,        32'h0000F100, 2, 1, 32'h0,     4'h0, 32'h0,       32'h000000F1, 1, 0));
`ifdef MISALIGN_TRAP_EN
        tbl.push_back(mk(1, 2, 0, 10, 32'h1,       32'h0,        32'hCAFEBABE, 0, 0, 32'h0,     4'h0, 32'h0,       32'h0,        0, 1));
        tbl.push_back(mk(2, 2, 0, 11, 32'h2,       32'hA5A51234, 32'h0,        0, 0, 32'h0,     4'h0, 32'h0,       32'h0,        0, 1));
`else
        tbl.push_back(mk(1, 2, 0, 10, 32'h1,       32'h0,        32'hCAFEBABE, 1, 1, 32'h0,     4'h0, 32'h0,       32'hCAFEBABE, 1, 0));
        tbl.push_back(mk(2, 2, 0, 11, 32'h2,       32'hA5A51234, 32'h0,        0, 1, 32'h0,     4'hF, 32'hA5A51234, 32'h0,       0, 0));
`endif
        foreach (tbl[i]) run_op(tbl[i], $sformatf("vec%0d", i));

        // Result backpressure on a NONE op; a pending op must wait.
        in_valid = 1; in_mem_op = 0; in_rd_addr = 9; in_rd_data = 32'h77; out_ready = 0;
        @(posedge clk); #1;
        in_rd_addr = 12; in_rd_data = 32'h88;
        for (int i = 0; i < 3; i++) begin
            chk("bp out_valid", 32'(out_valid), 32'd1);
            chk("bp in_ready", 32'(in_ready), 32'd0);
            chk("bp out_rd_data", out_rd_data, 32'h77);
            @(posedge clk); #1;
        end
        out_ready = 1;
        @(posedge clk); #1;
        in_valid = 0;
        chk("bp next_data", out_rd_data, 32'h88);
        chk("bp next_addr", 32'(out_rd_addr), 32'd12);
        @(posedge clk); #1;
        chk("bp drained", 32'(out_valid), 32'd0);

        // Back-to-back NONE ops, one per cycle.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_mem_op = 0; in_rd_addr = 5'(i + 1); in_rd_data = 32'h100 + 32'(i);
            chk("b2b in_ready", 32'(in_ready), 32'd1);
            @(posedge clk); #1;
            chk("b2b out_valid", 32'(out_valid), 32'd1);
            chk("b2b out_rd_data", out_rd_data, 32'h100 + 32'(i));
        end
        in_valid = 0;
        @(posedge clk); #1;
        chk("b2b drained", 32'(out_valid), 32'd0);

        // Load result held in DONE under backpressure.
        in_valid = 1; in_mem_op = 1; in_size = 0; in_signed = 0; in_rd_addr = 13; in_rd_data = 32'h40;
        @(posedge clk); #1;
        in_valid = 0; out_ready = 0; bus_ack = 1; bus_rdata = 32'h1111115A;
        @(posedge clk); #1;
        bus_ack = 0; bus_rdata = 32'h0;
        for (int i = 0; i < 2; i++) begin
            chk("done_hold out_valid", 32'(out_valid), 32'd1);
            chk("done_hold data", out_rd_data, 32'h5A);
            chk("done_hold in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1;
        @(posedge clk); #1;
        chk("done_hold release", 32'(out_valid), 32'd0);

        // Reset in the middle of a bus transfer, late ack ignored.
        in_valid = 1; in_mem_op = 1; in_size = 2; in_rd_addr = 14; in_rd_data = 32'h200;
        @(posedge clk); #1;
        in_valid = 0;
        chk("rst_bus req_before", 32'(bus_req), 32'd1);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0; bus_ack = 1; bus_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        bus_ack = 0;
        chk("rst_bus bus_req", 32'(bus_req), 32'd0);
        chk("rst_bus out_valid", 32'(out_valid), 32'd0);
        chk("rst_bus in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        chk("rst_bus still_idle", 32'(out_valid), 32'd0);

        // Randomized ops against the byte-level model.
        for (int i = 0; i < 300; i++) begin
            v.op = 2'($urandom); v.sz = 2'($urandom); v.sgn = 1'($urandom);
            v.rd = 5'($urandom); v.a = $urandom; v.md = $urandom; v.rdata = $urandom;
            v.dly = $urandom_range(0, 3);
            v = model(v);
            run_op(v, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
